sha1_msg_padder: RTL

SHA1_MSG_PADDER -- requirements
Module: sha1_msg_padder

---
 rtl/sha1_msg_padder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks and appends 0x80, zero fill and the 64-bit length.
// Optional status outputs (msg_bits, blk_count) are enabled by defining SHA1_PAD_STATUS_EN.
module sha1_msg_padder (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_last
`ifdef SHA1_PAD_STATUS_EN
   ,
   output logic [63:0]  msg_bits,
   output logic [15:0]  blk_count
`endif
);

   typedef enum logic [1:0] {S_FILL, S_EMIT, S_TAIL} state_t;

   state_t        state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [60:0]   cnt_q, cnt_d;
   logic [511:0]  blk_q, blk_d;
   logic [63:0]   len_q, len_d;
   logic          tail_pend_q, tail_pend_d;
   logic          tail_80_q, tail_80_d;
   logic          blk_valid_q, blk_valid_d;
   logic          blk_last_q, blk_last_d;

   logic [60:0]   cnt_inc;
   logic [63:0]   bits_inc;
   logic [5:0]    idx_inc;
   logic [8:0]    wr_pos;
   logic [8:0]    mk_pos;

`ifdef SHA1_PAD_STATUS_EN
   logic [63:0]   msg_bits_q, msg_bits_d;
   logic [15:0]   blk_count_q, blk_count_d;
`endif

   // Byte i of the block sits at bits [511-8i -: 8]; 511-8i is the bitwise inverse of 8i in 9 bits.
   assign cnt_inc  = cnt_q + 61'd1;
   assign bits_inc = {cnt_inc, 3'b000};
   assign idx_inc  = idx_q + 6'd1;
   assign wr_pos   = ~{idx_q, 3'b000};
   assign mk_pos   = ~{idx_inc, 3'b000};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      blk_d       = blk_q;
      len_d       = len_q;
      tail_pend_d = tail_pend_q;
      tail_80_d   = tail_80_q;
      blk_valid_d = blk_valid_q;
      blk_last_d  = blk_last_q;
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               blk_d[wr_pos -: 8] = in_data;
               cnt_d = cnt_inc;
               if (in_last) begin
                  len_d       = bits_inc;
                  state_d     = S_EMIT;
                  blk_valid_d = 1'b1;
                  if (idx_q <= 6'd54) begin
                     blk_d[mk_pos -: 8] = 8'h80;
                     blk_d[63:0]        = bits_inc;
                     blk_last_d         = 1'b1;
                  end else if (idx_q != 6'd63) begin
                     // Marker fits but the length does not: length goes in a tail block.
                     blk_d[mk_pos -: 8] = 8'h80;
                     tail_pend_d        = 1'b1;
                     tail_80_d          = 1'b0;
                     blk_last_d         = 1'b0;
                  end else begin
                     tail_pend_d = 1'b1;
                     tail_80_d   = 1'b1;
                     blk_last_d  = 1'b0;
                  end
               end else if (idx_q == 6'd63) begin
                  state_d     = S_EMIT;
                  blk_valid_d = 1'b1;
                  blk_last_d  = 1'b0;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         S_EMIT: begin
            if (blk_ready) begin
               blk_valid_d = 1'b0;
               blk_last_d  = 1'b0;
               if (blk_last_q) cnt_d = '0;
               if (tail_pend_q) begin
                  state_d = S_TAIL;
               end else begin
                  state_d = S_FILL;
                  idx_d   = '0;
                  blk_d   = '0;
               end
            end
         end
         S_TAIL: begin
            blk_d = '0;
            if (tail_80_q) blk_d[511:504] = 8'h80;
            blk_d[63:0] = len_q;
            blk_last_d  = 1'b1;
            blk_valid_d = 1'b1;
            tail_pend_d = 1'b0;
            state_d     = S_EMIT;
         end
         default: state_d = S_FILL;
      endcase
   end

`ifdef SHA1_PAD_STATUS_EN
   always_comb begin
      msg_bits_d  = msg_bits_q;
      blk_count_d = blk_count_q;
      if (blk_valid_q && blk_ready) begin
         blk_count_d = blk_count_q + 16'd1;
         if (blk_last_q) msg_bits_d = len_q;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FILL;
         idx_q       <= '0;
         cnt_q       <= '0;
         blk_q       <= '0;
         len_q       <= '0;
         tail_pend_q <= 1'b0;
         tail_80_q   <= 1'b0;
         blk_valid_q <= 1'b0;
         blk_last_q  <= 1'b0;
`ifdef SHA1_PAD_STATUS_EN
         msg_bits_q  <= '0;
         blk_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         len_q       <= len_d;
         tail_pend_q <= tail_pend_d;
         tail_80_q   <= tail_80_d;
         blk_valid_q <= blk_valid_d;
         blk_last_q  <= blk_last_d;
`ifdef SHA1_PAD_STATUS_EN
         msg_bits_q  <= msg_bits_d;
         blk_count_q <= blk_count_d;
`endif
      end
   end

   // Gating with reset keeps in_ready low for the whole reset, then high on the first free cycle.
   assign in_ready  = (state_q == S_FILL) && !reset;
   assign blk_data  = blk_q;
   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;
`ifdef SHA1_PAD_STATUS_EN
   assign msg_bits  = msg_bits_q;
   assign blk_count = blk_count_q;
`endif

endmodule
